reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset generator for a single clock domain, the successor to the team's three-flop reset synchroniser. Async assertion of an `ext_reset_n` / `lock` combination is synchronised over a configurable number of stages and held for a minimum count. The block then releases `NUM_OUT` reset outputs one at a time, at a fixed spacing, so downstream blocks come out of reset in a defined order. It also accepts a synchronous software reset request that re-runs the sequence without touching the async path.

## Interface
- `SYNC_STAGES`, 3, synchroniser depth; must be ≥ 2.
- `HOLD_CYCLES`, 16, minimum count after synchronised release before output 0 deasserts; must be ≥ 1.
- `NUM_OUT`, 4, number of sequenced reset outputs; must be ≥ 1.
- `STAGE_GAP`, 8, cycles between successive output releases; must be ≥ 1.
- `clock` input 1: sole clock, rising edge.
- `ext_reset_n` input 1: external reset. Asynchronous, active-low.
- `lock` input 1: PLL lock. Low asserts reset asynchronously.
- `sw_reset` input 1: synchronous software reset request, active-high, level-sampled.
- `reset_n` output `NUM_OUT`: sequenced resets, active-low. Bit 0 releases first.
- `done` output 1: high when all outputs are released.
- `last_cause` output 2: cause of the most recent reset. `01` = async (`ext_reset_n`/`lock`), `10` = software.

## Operation
- Internal `asynch_reset_n = ext_reset_n & lock` drives the async clear of every flop in the block.
- Synchroniser: `SYNC_STAGES` flops cleared to 0 and shifting in 1. The last stage is `sync_n`.
- FSM states:
  - `HOLD` is the reset state.
  - `HOLD` → `RELEASE` when the hold counter completes.
  - `RELEASE` → `RUN` when bit `NUM_OUT-1` releases.
  - `RELEASE`/`RUN` → `HOLD` on `sw_reset`.
- `HOLD` counter:
  - Increments on every edge where `sync_n = 1` and `sw_reset = 0`.
  - Clears on any edge where `sync_n = 0` or `sw_reset = 1`.
  - On the edge where the counter equals `HOLD_CYCLES-1` and would increment: set `reset_n[0]`, clear the gap counter, enter `RELEASE`.
- `RELEASE`:
  - The gap counter counts edges. Every `STAGE_GAP` edges, the next `reset_n` bit is set.
  - On the edge that sets bit `NUM_OUT-1`, `done` is set and the FSM enters `RUN`.
  - With `NUM_OUT = 1`, the FSM goes from `HOLD` directly to `RUN`; `done` rises on the same edge as `reset_n[0]`.
- `sw_reset = 1` sampled in any state:
  - Synchronously clears all `reset_n` bits and `done`.
  - Enters `HOLD` with the counter cleared.
  - Holding `sw_reset` high keeps the block in `HOLD`.
- `reset_n` bits release in order only. Once released, a bit never reasserts except via `HOLD` entry. All bits reassert together.
- Counter widths are `$clog2` of the terminal count, minimum 1 bit. Counters never wrap; they saturate at the terminal state.

## Timing
- Reset values, held while `asynch_reset_n = 0`:
  - `reset_n = 0`, `done = 0`, all counters 0, state `HOLD`.
  - `last_cause = 01` (with the macro enabled).
- Assertion is asynchronous: all outputs go low with no clock needed.
- Edge numbering: edge 1 is the first rising edge after `asynch_reset_n` rises with setup met.
  - `sync_n` goes high at edge `SYNC_STAGES`.
  - `reset_n[i]` rises at edge `SYNC_STAGES + HOLD_CYCLES + i*STAGE_GAP`.
  - `done` rises with `reset_n[NUM_OUT-1]`.
  - Defaults: edges 19, 27, 35, 43.
- Software reset: outputs go low on edge k, the edge that samples `sw_reset = 1`.
  - If k is the last such edge, `reset_n[i]` rises at edge `k + HOLD_CYCLES + i*STAGE_GAP`.
  - Defaults: k+16, k+24, k+32, k+40.
- Async assertion mid-sequence (any state): immediate clear, and the sequence restarts from the synchroniser.
- Async assertion dominates a simultaneous `sw_reset`.
- `sw_reset` pulses during `HOLD` restart the hold count from 0.

## Configuration
- `RESET_SEQ_CAUSE_EN` defined:
  - `last_cause` is a register, set to `01` on async reset.
  - Set to `10` on any edge that samples `sw_reset = 1`.
  - Otherwise holds.
- Not defined: `last_cause` is tied to `2'b00` and no cause register is built. Sequencing behaviour is identical either way.

## Test plan
- Power-on, defaults: `ext_reset_n` and `lock` low, then `ext_reset_n` high before `lock` rises → `reset_n` stays 0 until `lock` rises. Counting from the first edge after `lock` rises, `reset_n` = `0001` at edge 19, `0011` at 27, `0111` at 35, `1111` with `done = 1` at 43.
- Lock loss in `RUN`: `lock` low for 2 ns between edges → `reset_n = 0000`, `done = 0` immediately, with no clock edge. The full 19/27/35/43 sequence repeats after `lock` returns.
- Software reset in `RUN`: `sw_reset` high for 1 cycle at edge k → `reset_n = 0000` at k. Releases at k+16, k+24, k+32, k+40. With the macro, `last_cause = 10`.
- Software reset held 5 cycles during `RELEASE` (after bit 1 is set) → all bits cleared at the first sampling edge. Releases are timed from the last edge that samples `sw_reset` high.
- Simultaneous `ext_reset_n` low and `sw_reset` high → async clear wins and `last_cause = 01`. Restart timing follows the async path.
- Parameter corner `SYNC_STAGES = 2`, `HOLD_CYCLES = 1`, `NUM_OUT = 1` → `reset_n[0]` and `done` both rise at edge 3. Without the macro, `last_cause` stays `00` throughout.

Source files
------------

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises ext_reset_n & lock, holds, then releases NUM_OUT resets in order.
// Optional macro RESET_SEQ_CAUSE_EN builds the last_cause register; otherwise last_cause reads 2'b00.
module reset_sequencer #(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUT     = 4,
    parameter int STAGE_GAP   = 8
) (
    input  logic               clock,
    input  logic               ext_reset_n,
    input  logic               lock,
    input  logic               sw_reset,
    output logic [NUM_OUT-1:0] reset_n,
    output logic               done,
    output logic [1:0]         last_cause
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } state_t;

    logic                   asynch_reset_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    state_t                 state_q;
    logic [HW-1:0]          hold_cnt_q;
    logic [GW-1:0]          gap_cnt_q;
    logic [NUM_OUT-1:0]     reset_n_q;
    logic                   done_q;
    logic [NUM_OUT-1:0]     next_mask_d;
    logic                   last_step_d;

    assign asynch_reset_n = ext_reset_n & lock;
    assign sync_n         = sync_q[SYNC_STAGES-1];

    // Release synchroniser: cleared asynchronously, shifts in ones.
    always_ff @(posedge clock or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    // Next release pattern: one more bit released, strictly in ascending order.
    always_comb begin
        next_mask_d    = {NUM_OUT{1'b0}};
        next_mask_d[0] = 1'b1;
        for (int i = 1; i < NUM_OUT; i++) begin
            next_mask_d[i] = reset_n_q[i-1];
        end
        last_step_d = &next_mask_d;
    end

    // Sequencing FSM with hold and gap counters; sw_reset re-enters HOLD from any state.
    always_ff @(posedge clock or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= {HW{1'b0}};
            gap_cnt_q  <= {GW{1'b0}};
            reset_n_q  <= {NUM_OUT{1'b0}};
            done_q     <= 1'b0;
        end else if (sw_reset) begin
            state_q    <= HOLD;
            hold_cnt_q <= {HW{1'b0}};
            gap_cnt_q  <= {GW{1'b0}};
            reset_n_q  <= {NUM_OUT{1'b0}};
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (!sync_n) begin
                        hold_cnt_q <= {HW{1'b0}};
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        // reset_n_q is all zero here, so next_mask_d releases bit 0 only
                        reset_n_q <= next_mask_d;
                        gap_cnt_q <= {GW{1'b0}};
                        done_q    <= last_step_d;
                        state_q   <= last_step_d ? RUN : RELEASE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        reset_n_q <= next_mask_d;
                        gap_cnt_q <= {GW{1'b0}};
                        if (last_step_d) begin
                            done_q  <= 1'b1;
                            state_q <= RUN;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= {HW{1'b0}};
                    gap_cnt_q  <= {GW{1'b0}};
                    reset_n_q  <= {NUM_OUT{1'b0}};
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign reset_n = reset_n_q;
    assign done    = done_q;

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_q;

    // Cause of the most recent reset: async path wins over a simultaneous software request.
    always_ff @(posedge clock or negedge asynch_reset_n) begin
        if (!asynch_reset_n) begin
            cause_q <= 2'b01;
        end else if (sw_reset) begin
            cause_q <= 2'b10;
        end else begin
            cause_q <= cause_q;
        end
    end

    assign last_cause = cause_q;
`else
    assign last_cause = 2'b00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus the SYNC=2/HOLD=1/NUM_OUT=1 corner, both
// compared every cycle against an edge-count model of the release schedule.
module tb_reset_sequencer;

    logic       clock;
    logic       ext_reset_n;
    logic       lock;
    logic       sw_reset;
    logic [3:0] rn_a;
    logic       done_a;
    logic [1:0] cause_a;
    logic [0:0] rn_b;
    logic       done_b;
    logic [1:0] cause_b;

    int         checks;
    int         failures;
    // Model: edges since async release, edge index of the last sampled sw_reset, last cause.
    int         ea;
    int         ks;
    logic [1:0] cause_m;

    reset_sequencer #(
        .SYNC_STAGES(3), .HOLD_CYCLES(16), .NUM_OUT(4), .STAGE_GAP(8)
    ) dut_a (
        .clock(clock), .ext_reset_n(ext_reset_n), .lock(lock), .sw_reset(sw_reset),
        .reset_n(rn_a), .done(done_a), .last_cause(cause_a)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .HOLD_CYCLES(1), .NUM_OUT(1), .STAGE_GAP(8)
    ) dut_b (
        .clock(clock), .ext_reset_n(ext_reset_n), .lock(lock), .sw_reset(sw_reset),
        .reset_n(rn_b), .done(done_b), .last_cause(cause_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at %0t: got=%h want=%h", tag, $time, got, want);
        end
    endtask

    // Bit i is released once ea reaches max(last sw edge, sync depth) + hold + i*gap; bit n is done.
    function automatic logic [31:0] model_out(input int s, input int h, input int n, input int g);
        logic [31:0] r;
        int          base;
        r    = 32'd0;
        base = (ks > s) ? ks : s;
        for (int i = 0; i < n; i++) begin
            if (ea >= base + h + i * g) r[i] = 1'b1;
        end
        if (r == ((32'd1 << n) - 32'd1)) r[n] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_cause();
`ifdef RESET_SEQ_CAUSE_EN
        return 32'(cause_m);
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all();
        check_val("seq_a",   32'({done_a, rn_a}), model_out(3, 16, 4, 8));
        check_val("cause_a", 32'(cause_a),        exp_cause());
        check_val("seq_b",   32'({done_b, rn_b}), model_out(2, 1, 1, 8));
        check_val("cause_b", 32'(cause_b),        exp_cause());
    endtask

    task automatic async_hit();
        ea      = 0;
        ks      = 0;
        cause_m = 2'b01;
    endtask

    task automatic step();
        logic sw_s;
        logic ar_s;
        sw_s = sw_reset;
        ar_s = ext_reset_n & lock;
        @(posedge clock);
        if (ar_s) begin
            ea++;
            if (sw_s) begin
                ks      = ea;
                cause_m = 2'b10;
            end
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called 1 ns after an edge: 2 ns low pulse, checked with no clock edge in between.
    task automatic drop_async(input logic use_lock);
        #2;
        if (use_lock) lock = 1'b0;
        else ext_reset_n = 1'b0;
        async_hit();
        #1;
        check_all();
        check_val("async_clear", 32'({done_a, rn_a}), 32'd0);
        #1;
        lock        = 1'b1;
        ext_reset_n = 1'b1;
    endtask

    // Directed spot checks of the default schedule: first release at relative edge 'base'.
    task automatic seq_edges(input int base);
        for (int e = 1; e <= base + 25; e++) begin
            step();
            if (e == base - 1) check_val("pre_rel", 32'({done_a, rn_a}), 32'h00);
            if (e == base)      check_val("rel0",    32'({done_a, rn_a}), 32'h01);
            if (e == base + 8)  check_val("rel1",    32'({done_a, rn_a}), 32'h03);
            if (e == base + 16) check_val("rel2",    32'({done_a, rn_a}), 32'h07);
            if (e == base + 24) check_val("rel3",    32'({done_a, rn_a}), 32'h1f);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        ext_reset_n = 1'b0;
        lock        = 1'b0;
        sw_reset    = 1'b0;
        async_hit();
        #1;
        check_all();

        // Power-on: ext_reset_n released before lock; nothing moves until lock rises.
        run(3);
        ext_reset_n = 1'b1;
        run(4);
        lock = 1'b1;
        seq_edges(19);

        // Lock loss in RUN, then the full sequence again.
        drop_async(1'b1);
        seq_edges(19);

        // One-cycle software reset in RUN.
        sw_reset = 1'b1;
        step();
        check_val("sw_clear", 32'({done_a, rn_a}), 32'd0);
        sw_reset = 1'b0;
        seq_edges(16);

        // Software reset held 5 cycles during RELEASE after bit 1 released.
        drop_async(1'b0);
        run(27);
        check_val("mid_rel", 32'(rn_a), 32'h3);
        sw_reset = 1'b1;
        run(5);
        sw_reset = 1'b0;
        seq_edges(16);

        // Async clear and sw_reset together: async wins.
        ext_reset_n = 1'b0;
        sw_reset    = 1'b1;
        async_hit();
        #1;
        check_all();
        run(3);
        sw_reset    = 1'b0;
        ext_reset_n = 1'b1;
        seq_edges(19);

        // Randomised mix of idle time, software pulses and async drops.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0: run($urandom_range(1, 50));
                1: begin
                    sw_reset = 1'b1;
                    run($urandom_range(1, 4));
                    sw_reset = 1'b0;
                    run($urandom_range(1, 45));
                end
                2: begin
                    drop_async(1'($urandom_range(0, 1)));
                    run($urandom_range(1, 30));
                end
                3: begin
                    sw_reset = 1'b1;
                    drop_async(1'($urandom_range(0, 1)));
                    run(1);
                    sw_reset = 1'b0;
                    run($urandom_range(1, 45));
                end
                default: run(1);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
